// File: rtl/imem_arbiter.sv
// Shared instruction-memory port arbiter: a loader owns the port during BOOT, then fetch
// and loader share it in RUN with a starvation limit that pushes the loader ahead.
//
// state | meaning
// BOOT  | only the loader is served, fetch is held off
// RUN   | fetch has priority until the loader has waited STARVE_MAX grants
module imem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter bit BOOT_HOLD  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        fetch_hold,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    input  logic        boot_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam state_t     RST_STATE  = BOOT_HOLD ? BOOT : RUN;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       owner_f;
    logic       owner_l;
    logic       unused_addr_lsbs;

    assign unused_addr_lsbs = ^{f_addr[1:0], l_addr[1:0]};

    // Grants are combinational so the memory sees the winning request in the same cycle.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (state == BOOT) begin
                l_gnt = l_req;
            end else if (f_req && !(l_req && starve_cnt == STARVE_LIM)) begin
                f_gnt = 1'b1;
            end else begin
                l_gnt = l_req;
            end
        end
    end

    assign mem_en     = f_gnt | l_gnt;
    assign mem_we     = l_gnt & l_we;
    assign mem_addr   = l_gnt ? l_addr[31:2] : (f_gnt ? f_addr[31:2] : 30'd0);
    assign mem_wdata  = l_gnt ? l_wdata : 32'd0;
    assign fetch_hold = (state == BOOT) | (f_req & ~f_gnt);

    // Masking with rst drops a response that was pending when reset arrived.
    assign f_rvalid = owner_f & ~rst;
    assign l_rvalid = owner_l & ~rst;
    assign f_rdata  = rst ? 32'd0 : mem_rdata;
    assign l_rdata  = rst ? 32'd0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_STATE;
            starve_cnt <= 4'd0;
            owner_f    <= 1'b0;
            owner_l    <= 1'b0;
        end else begin
            owner_f <= f_gnt;
            owner_l <= l_gnt;
            if (state == BOOT && boot_done) begin
                state <= RUN;
            end
            if (l_gnt || !l_req) begin
                starve_cnt <= 4'd0;
            end else if (f_gnt && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4 -- consecutive cycles the loader may wait while fetch is granted before it is forced ahead (legal range 1..15).
REQ-002 Parameter: BOOT_HOLD, default 1 -- 1: come out of reset in BOOT state, 0: come out of reset in RUN state.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  32  fetch read data.
- fetch_hold  out  1  stall to fetch stage; asserted when f_req=1 and f_gnt=0, and throughout BOOT.
- l_req  in  1  loader request.
- l_we  in  1  loader write enable.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader read data valid, or write acknowledge.
- l_rdata  out  32  loader read data.
- boot_done  in  1  single-cycle pulse; ends BOOT.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  30  word address, taken from addr[31:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  synchronous read data, valid 1 cycle after mem_en.

Function
REQ-004 There is a single shared memory port; at most one grant is issued per cycle (f_gnt & l_gnt is never 1).
REQ-005 States:
- BOOT: only the loader is served; f_gnt=0; fetch_hold=1.
- RUN: arbitration per REQ-006.
- BOOT->RUN: on boot_done=1, effective the next cycle.
- RUN does not return to BOOT.
REQ-006 RUN arbitration:
- Grant fetch if f_req=1 and not (l_req=1 and starve_cnt==STARVE_MAX).
- Otherwise grant the loader if l_req=1.
- Otherwise no grant and mem_en=0.
REQ-007 starve_cnt (4-bit):
- Increments when l_req=1 and fetch is granted.
- Clears when the loader is granted or l_req=0.
- Saturates at STARVE_MAX.
REQ-008 Grant path is combinational: mem_en, mem_we, mem_addr and mem_wdata are driven in the grant cycle from the granted requester. mem_we=l_we only when the loader is granted, else 0.
REQ-009 Response routing:
- The owner of each grant is registered.
- In the next cycle, exactly one of f_rvalid/l_rvalid pulses for 1 cycle.
- f_rdata/l_rdata = mem_rdata.
- A loader write also returns l_rvalid (ack); l_rdata is don't-care for writes.
REQ-010 Back-to-back grants are allowed every cycle; throughput is 1 access/cycle; read latency is exactly 1 cycle from grant.
REQ-011 Simultaneous boot_done and l_req in BOOT: the loader is granted in that cycle; RUN arbitration starts the next cycle.
REQ-012 f_req in BOOT is ignored (not queued); the requester holds f_req, and fetch_hold stays 1.
REQ-013 Requesters hold req/addr/wdata stable until granted; the arbiter keeps no request buffer.

Reset
REQ-014 While rst=1:
- State becomes BOOT (BOOT_HOLD=1) or RUN (BOOT_HOLD=0).
- starve_cnt=0; owner register cleared.
- All grant, valid and mem_en/mem_we outputs are 0.
- rdata outputs are 0.
REQ-015 Reset mid-transaction: any response pending for the cycle after rst is dropped (no rvalid).

Verification
REQ-016 Boot load:
- BOOT_HOLD=1, f_req=1, three loader writes to 0x0, 0x4, 0x8 -> l_gnt each cycle, l_rvalid 1 cycle later, f_gnt=0, fetch_hold=1.
- boot_done pulse -> f_gnt=1 on the next cycle.
REQ-017 Fetch stream: RUN, f_req=1 continuous, addr 0x0,0x4,... -> f_rvalid every cycle, f_rdata = mem[word] 1 cycle after each grant.
REQ-018 Starvation: RUN, f_req=1 and l_req=1 held (STARVE_MAX=4) -> fetch granted 4 cycles, loader granted the 5th cycle with fetch_hold=1, fetch resumes the 6th cycle.
REQ-019 Read-after-write: in RUN, loader writes 0xDEADBEEF to 0x40, then fetch reads 0x40 -> f_rdata=0xDEADBEEF.
REQ-020 Reset mid-operation: rst asserted the cycle after a fetch grant -> no f_rvalid, state BOOT, all outputs 0.
REQ-021 Boundary case: boot_done with l_req the same cycle -> loader granted, then fetch granted the next cycle, with no double grant in any cycle.
